// File: rtl/tick_mon_pkg.sv
// Shared types and window-bound helpers for the tick period monitor.
package tick_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LOCKED,
        FAULT
    } tm_state_t;

    // Classification of a measured interval against the acceptance window.
    typedef enum logic [1:0] {
        IN_WIN,
        EARLY,
        LATE
    } tm_cmp_t;

    // Lowest accepted interval; clamps at 0 if the tolerance exceeds the period.
    function automatic int unsigned win_lo(input int unsigned period, input int unsigned tol);
        return (tol > period) ? 32'd0 : period - tol;
    endfunction

    // Highest accepted interval.
    function automatic int unsigned win_hi(input int unsigned period, input int unsigned tol);
        return period + tol;
    endfunction

    // Measured interval at which a missing tick is declared late.
    function automatic int unsigned timeout_len(input int unsigned period,
                                                input int unsigned tol);
        return period + tol + 32'd1;
    endfunction

endpackage

// File: rtl/tick_interval_counter.sv
// Cycles-since-last-tick counter with saturation, window classification and timeout strobe.
module tick_interval_counter
    import tick_mon_pkg::*;
#(
    parameter int unsigned PERIOD = 15001,
    parameter int unsigned TOL    = 2,
    parameter int unsigned PBITS  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    output logic [PBITS-1:0] measured_o,
    output tm_cmp_t          cmp_o,
    output logic             timeout_o
);

    localparam int unsigned MaxIvl = (32'd1 << PBITS) - 32'd1;
    localparam int unsigned WinLoI = win_lo(PERIOD, TOL);
    localparam int unsigned WinHiI = win_hi(PERIOD, TOL);
    localparam int unsigned TmoI   = timeout_len(PERIOD, TOL);

    localparam logic [PBITS:0] WinLo = WinLoI[PBITS:0];
    localparam logic [PBITS:0] WinHi = WinHiI[PBITS:0];
    localparam logic [PBITS:0] TmoVal = TmoI[PBITS:0];

    // The timeout value must be reachable by the counter, or late detection never fires.
    if (MaxIvl < TmoI) begin : g_width_check
        $error("tick_interval_counter: PBITS too small for PERIOD+TOL+1");
    end

    logic [PBITS-1:0] ivl_q, ivl_d;
    logic [PBITS:0]   meas_wide;

    // Next interval count: restart on tick, otherwise count up and stick at all-ones.
    always_comb begin
        ivl_d = ivl_q;
        if (tick_i) begin
            ivl_d = '0;
        end else if (ivl_q != {PBITS{1'b1}}) begin
            ivl_d = ivl_q + 1'b1;
        end
    end

    // Interval counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ivl_q <= '0;
        end else begin
            ivl_q <= ivl_d;
        end
    end

    // Measured interval is one wider so the +1 can be saturated rather than wrapped.
    always_comb begin
        meas_wide  = {1'b0, ivl_q} + {{PBITS{1'b0}}, 1'b1};
        measured_o = meas_wide[PBITS] ? {PBITS{1'b1}} : meas_wide[PBITS-1:0];
        cmp_o      = IN_WIN;
        if (meas_wide < WinLo) begin
            cmp_o = EARLY;
        end else if (meas_wide > WinHi) begin
            cmp_o = LATE;
        end
        // A tick in the timeout cycle takes precedence over the timeout.
        timeout_o = !tick_i && (meas_wide == TmoVal);
    end

endmodule

// File: rtl/tick_period_monitor.sv
// Locks onto a periodic tick and raises a sticky fault on early, late or missing ticks.
module tick_period_monitor
    import tick_mon_pkg::*;
#(
    parameter int unsigned PERIOD   = 15001,
    parameter int unsigned TOL      = 2,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned PBITS    = 15,
    parameter int unsigned CBITS    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    output logic             locked,
    output logic             fault,
    output logic             early,
    output logic             late,
    output logic [PBITS-1:0] period,
    output logic [CBITS-1:0] tick_count
);

    localparam int unsigned GBits = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [GBits-1:0] LockVal = LOCK_CNT[GBits-1:0];

    tm_state_t        state_q, state_d;
    logic [GBits-1:0] good_q, good_d;
    logic [GBits-1:0] good_inc;
    logic             locked_q, locked_d;
    logic             fault_q, fault_d;
    logic             early_q, early_d;
    logic             late_q, late_d;
    logic [PBITS-1:0] period_q, period_d;
    logic [CBITS-1:0] cnt_q, cnt_d;

    logic [PBITS-1:0] measured;
    tm_cmp_t          cmp;
    logic             timeout;

    tick_interval_counter #(
        .PERIOD (PERIOD),
        .TOL    (TOL),
        .PBITS  (PBITS)
    ) u_ivl (
        .clk        (clk),
        .rst        (rst),
        .tick_i     (tick),
        .measured_o (measured),
        .cmp_o      (cmp),
        .timeout_o  (timeout)
    );

    assign good_inc = good_q + 1'b1;

    // Next state, lock qualification counter, pulses and measurement registers.
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        early_d  = 1'b0;
        late_d   = 1'b0;
        period_d = period_q;
        cnt_d    = cnt_q;

        if (tick) begin
            if (cnt_q != {CBITS{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
            // The first tick after reset is only a reference point, not an interval.
            period_d = (state_q == IDLE) ? '0 : measured;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SYNC;
                    good_d  = '0;
                end
            end
            SYNC: begin
                if (tick) begin
                    if (cmp == IN_WIN) begin
                        good_d = good_inc;
                        if (good_inc == LockVal) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout) begin
                    good_d = '0;
                end
            end
            LOCKED: begin
                if (tick) begin
                    if (cmp == EARLY) begin
                        early_d = 1'b1;
                        state_d = FAULT;
                    end else if (cmp == LATE) begin
                        late_d  = 1'b1;
                        state_d = FAULT;
                    end
                end else if (timeout) begin
                    late_d  = 1'b1;
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (clr) begin
                    state_d = SYNC;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                good_d  = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
        fault_d  = (state_d == FAULT);
    end

    // State and output registers; reset discards all history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            good_q   <= '0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            early_q  <= 1'b0;
            late_q   <= 1'b0;
            period_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
            early_q  <= early_d;
            late_q   <= late_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

    assign locked     = locked_q;
    assign fault      = fault_q;
    assign early      = early_q;
    assign late       = late_q;
    assign period     = period_q;
    assign tick_count = cnt_q;

endmodule
